// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops MEMORY_WIDTH-bit words and presents
// PACK_COUNT of them as one valid/ready beat, with a flush path for partial beats.
module fifo_rd_packer #(
  parameter int MEMORY_WIDTH = 4,
  parameter int PACK_COUNT   = 4,
  parameter int CNT_W        = 3
) (
  input  logic                               r_clk,
  input  logic                               rrst,
  input  logic                               r_empty,
  input  logic [MEMORY_WIDTH-1:0]            rdata,
  output logic                               r_en,
  input  logic                               flush,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [MEMORY_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [CNT_W-1:0]                   out_words
);

  if (PACK_COUNT < 2 || PACK_COUNT > 16) begin : g_bad_pack_count
    $error("fifo_rd_packer: PACK_COUNT must be in 2..16");
  end
  if ((1 << CNT_W) <= PACK_COUNT) begin : g_bad_cnt_w
    $error("fifo_rd_packer: CNT_W too narrow for PACK_COUNT");
  end

  localparam logic [CNT_W:0] PACK_N = (CNT_W+1)'(PACK_COUNT);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                                  state_p0, state_nxt;
  logic [CNT_W-1:0]                        cnt_p0, cnt_nxt;
  logic                                    inflight_p0;
  logic                                    pend_flush_p0, pend_flush_nxt;
  logic [PACK_COUNT-1:0][MEMORY_WIDTH-1:0] slot_p0;
  logic                                    capture;
  logic                                    handshake;

  // True while captured words plus the outstanding pop still leave a free slot.
  function automatic logic room_left(input logic [CNT_W-1:0] cnt, input logic inflight);
    return ({1'b0, cnt} + {{CNT_W{1'b0}}, inflight}) < PACK_N;
  endfunction

  always_comb begin
    state_nxt      = state_p0;
    cnt_nxt        = cnt_p0;
    pend_flush_nxt = pend_flush_p0;
    r_en           = 1'b0;
    capture        = 1'b0;
    handshake      = 1'b0;
    case (state_p0)
      FILL: begin
        capture = inflight_p0;
        r_en    = !r_empty && room_left(cnt_p0, inflight_p0) && !pend_flush_p0;
        if (capture) begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
        if (flush && (cnt_p0 != '0 || inflight_p0)) begin
          pend_flush_nxt = 1'b1;
        end
        if (capture && ({1'b0, cnt_nxt} == PACK_N)) begin
          state_nxt = HOLD;
        end else if (pend_flush_p0 && !inflight_p0 && cnt_p0 != '0) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // The slot bank frees up on the handshake edge, so the next pop may overlap it.
        handshake = out_ready;
        if (handshake) begin
          r_en           = !r_empty;
          cnt_nxt        = '0;
          pend_flush_nxt = 1'b0;
          state_nxt      = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
    if (rrst) begin
      r_en = 1'b0;
    end
  end

  // Stage p0: control and slot registers; a reset discards any pop in flight.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_p0      <= FILL;
      cnt_p0        <= '0;
      inflight_p0   <= 1'b0;
      pend_flush_p0 <= 1'b0;
      slot_p0       <= '0;
    end else begin
      state_p0      <= state_nxt;
      cnt_p0        <= cnt_nxt;
      inflight_p0   <= r_en;
      pend_flush_p0 <= pend_flush_nxt;
      if (handshake) begin
        slot_p0 <= '0;
      end else if (capture) begin
        for (int i = 0; i < PACK_COUNT; i++) begin
          if (cnt_p0 == CNT_W'(i)) begin
            slot_p0[i] <= rdata;
          end
        end
      end
    end
  end

  assign out_valid = (state_p0 == HOLD);
  assign out_data  = slot_p0;
  assign out_words = cnt_p0;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small behavioural model of the FIFO read port.
module tb_fifo_rd_packer;

  logic        r_clk = 1'b0;
  logic        rrst = 1'b1;
  logic        r_empty;
  logic [3:0]  rdata = '0;
  logic        r_en;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_words;

  logic        fifo_clr = 1'b1;
  logic [3:0]  mem [0:63];
  logic [5:0]  rd_ptr = '0;
  logic [5:0]  wr_ptr = '0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          viol = 0;

  fifo_rd_packer #(.MEMORY_WIDTH(4), .PACK_COUNT(4), .CNT_W(3)) dut (
    .r_clk     (r_clk),
    .rrst      (rrst),
    .r_empty   (r_empty),
    .rdata     (rdata),
    .r_en      (r_en),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_words (out_words)
  );

  always #5 r_clk = ~r_clk;

  // FIFO read port: pop on r_en && !r_empty, word appears on rdata the next cycle.
  assign r_empty = (rd_ptr == wr_ptr);
  always @(posedge r_clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (r_en && !r_empty) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always @(negedge r_clk) begin
    if (r_en && r_empty) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    fifo_clr = 1'b1;
    flush = 1'b0;
    repeat (2) next_cycle();
    fifo_clr = 1'b0;
  endtask

  // Called at a negedge; returns the number of further cycles until out_valid.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      @(negedge r_clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // Basic fill and latency
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i));
    @(negedge r_clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ren", r_en, 0);
    chk("rst_data", out_data, 0);
    chk("rst_words", out_words, 0);
    next_cycle();
    rrst = 1'b0;
    @(negedge r_clk);
    chk("c0_ren", r_en, 1);
    wait_valid(20, n);
    chk("latency", n, 5);
    chk("t1_data", out_data, 32'h4321);
    chk("t1_words", out_words, 4);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    next_cycle();
    rrst = 1'b0;
    @(negedge r_clk);
    wait_valid(20, n);
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 32'h4321);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge r_clk);
      if (r_en !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h4321) bad++;
    end
    chk("t2_hold_stable", bad, 0);
    next_cycle();
    out_ready = 1'b1;
    @(negedge r_clk);
    chk("t2_hs_pop", r_en, 1);
    @(negedge r_clk);
    wait_valid(20, n);
    chk("t2_data2", out_data, 32'h8765);
    chk("t2_words2", out_words, 4);
    chk("t2_drained", r_empty, 1);

    // Flush while second word in flight
    do_reset();
    out_ready = 1'b0;
    push(4'hA);
    push(4'hB);
    next_cycle();
    rrst = 1'b0;
    next_cycle();
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    push(4'hC);
    @(negedge r_clk);
    chk("t3_no_pop", r_en, 0);
    wait_valid(20, n);
    chk("t3_latency", n, 1);
    chk("t3_data", out_data, 32'h00BA);
    chk("t3_words", out_words, 2);
    next_cycle();
    @(negedge r_clk);
    chk("t3_hold_no_pop", r_en, 0);

    // Ignored flushes
    do_reset();
    out_ready = 1'b0;
    next_cycle();
    rrst = 1'b0;
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    @(negedge r_clk);
    wait_valid(20, n);
    chk("t4_latency", n, 5);
    chk("t4_data", out_data, 32'h4321);
    chk("t4_words", out_words, 4);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge r_clk);
    chk("t4_hold_data", out_data, 32'h4321);
    chk("t4_hold_words", out_words, 4);
    @(negedge r_clk);
    wait_valid(20, n);
    chk("t4_data2", out_data, 32'h8765);
    chk("t4_words2", out_words, 4);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i));
    next_cycle();
    rrst = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rrst = 1'b1;
    fifo_clr = 1'b1;
    @(negedge r_clk);
    chk("t5_rst_ren", r_en, 0);
    next_cycle();
    rrst = 1'b0;
    fifo_clr = 1'b0;
    @(negedge r_clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_words", out_words, 0);
    chk("t5_ren", r_en, 0);
    next_cycle();
    for (int i = 5; i <= 8; i++) push(4'(i));
    @(negedge r_clk);
    wait_valid(20, n);
    chk("t5_refill_data", out_data, 32'h8765);
    chk("t5_refill_words", out_words, 4);

    // FIFO starves after three words
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) push(4'(i));
    next_cycle();
    rrst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      @(negedge r_clk);
      if (i >= 3 && r_en !== 1'b0) bad++;
      if (out_valid !== 1'b0) bad++;
    end
    chk("t6_starved_idle", bad, 0);
    next_cycle();
    push(4'h4);
    @(negedge r_clk);
    chk("t6_refill_pop", r_en, 1);
    wait_valid(20, n);
    chk("t6_latency", n, 2);
    chk("t6_data", out_data, 32'h4321);
    chk("t6_words", out_words, 4);

    chk("ren_while_empty", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
